// File: rtl/fetch_unit.sv
// fetch_unit: PC, req/ack instruction fetch, instruction latch/field split and next-PC sequencing.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned next PC traps instead of being forced word-aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [1:0]  pcsel,
  input  logic        brtaken,
  input  logic [31:0] aluresult,
  input  logic [31:0] immext,
  input  logic        ramR,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        commit,
  output logic        trap
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] MEMWAIT = 3'd3;
  localparam logic [2:0] TRAP    = 3'd4;

  logic [2:0]  state;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        misalign;
  logic        retire;

  always_comb begin
    target = pc + 32'd4;
    case (pcsel)
      2'b01:   target = aluresult & ~32'h1;
      2'b10:   if (brtaken) target = pc + immext;
      2'b11:   target = pc + immext;
      default: target = pc + 32'd4;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc  = target;
    misalign = (target[1:0] != 2'b00);
`else
    next_pc  = target & ~32'h3;
    misalign = 1'b0;
`endif
  end

  // Handshake outputs are forced low while reset is held so a reset in MEMWAIT never commits.
  assign retire      = nReset && ((state == EXEC && !ramR) || state == MEMWAIT);
  assign commit      = retire && !misalign;
  assign imem_req    = nReset && (state == FETCH);
  assign instr_valid = nReset && (state == EXEC || state == MEMWAIT);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap        = nReset && (state == TRAP);
`else
  assign trap        = 1'b0;
`endif

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign funct7    = instr[31:25];

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (ramR) begin
            state <= MEMWAIT;
          end else if (misalign) begin
            state <= TRAP;
          end else begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        MEMWAIT: begin
          if (misalign) begin
            state <= TRAP;
          end else begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage of the RISC-V core, directly upstream of the decoder. Holds the PC, fetches one instruction per step from instruction memory over a req/ack handshake, latches it and splits it into the opcode/funct7/funct3/register fields the decoder consumes. Consumes the decoder's `pcsel` and `ramR` to compute the next PC and to add the extra cycle a load needs before write-back. Emits a one-cycle `commit` pulse that gates register-file and RAM writes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, instruction register reset value (addi x0,x0,0).

- `clock`  in  1  system clock; all state changes on rising edge.
- `nReset`  in  1  reset, synchronous and active-low.
- `pcsel`  in  2  from decoder: 00 pc+4, 01 jalr, 10 branch, 11 jal.
- `brtaken`  in  1  branch condition result from the ALU; sampled only when `pcsel`=10.
- `aluresult`  in  32  ALU output; jalr target (rs1+imm).
- `immext`  in  32  sign-extended immediate; branch/jal offset.
- `ramR`  in  1  from decoder; current instruction is a load.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address (= `pc`).
- `imem_ack`  in  1  instruction data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  latched instruction.
- `opcode`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7`  out  7  `instr[31:25]`.
- `rd`, `rs1`, `rs2`  out  5 each  `instr[11:7]`, `[19:15]`, `[24:20]`.
- `instr_valid`  out  1  `instr` is live for decode/execute.
- `pc`  out  32  address of the current instruction.
- `pc4`  out  32  `pc`+4, link value for jal/jalr write-back.
- `commit`  out  1  one-cycle pulse; current instruction retires and PC updates at this edge.
- `trap`  out  1  misaligned-target trap (see Configuration).

## Operation
- FSM states: IDLE, FETCH, EXEC, MEMWAIT, TRAP.
- IDLE → FETCH unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`=1, latch `imem_rdata` into `instr` and go to EXEC. Otherwise stay in FETCH, `pc` stable.
- EXEC: `instr_valid`=1.
  - If `ramR`=1, go to MEMWAIT with `commit`=0.
  - Otherwise `commit`=1, `pc`←next, go to FETCH.
- MEMWAIT: `instr_valid`=1, `instr` held, `commit`=1, `pc`←next, go to FETCH.
- Next PC, all arithmetic mod 2^32, wrap silently:
  - 00: `pc`+4.
  - 01: `aluresult` & ~32'h1.
  - 10: `brtaken` ? `pc`+`immext` : `pc`+4.
  - 11: `pc`+`immext`.
- `imem_ack` is ignored outside FETCH. `instr_valid`=0 in IDLE and FETCH. Field outputs always reflect `instr`.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=NOP_INSTR, state IDLE, `imem_req`=0, `instr_valid`=0, `commit`=0, `trap`=0.
- `imem_req` is 0 during reset and for the first cycle after reset release.
- Zero-wait memory (`imem_ack` in the same cycle as `imem_req`):
  - Non-load instruction: 2 cycles (FETCH, EXEC).
  - Load: 3 cycles (FETCH, EXEC, MEMWAIT).
- Each wait cycle of `imem_ack` adds one cycle in FETCH.
- `commit` is high for exactly one cycle per instruction, in its last cycle. The new `pc` is visible the cycle after.
- `pc4` is combinational from `pc`.
- Reset asserted in any state, including mid-fetch or MEMWAIT: next state IDLE, `pc`=RESET_PC, and any in-flight ack is discarded.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A computed next PC with bits [1:0]≠00 (after the jalr bit-0 clear) does not update `pc`.
  - `commit`=0 in that cycle, the FSM goes to TRAP, and `trap`=1.
  - TRAP holds until reset. `imem_req`=0 and `instr_valid`=0 in TRAP.
- Not defined:
  - Next PC bits [1:0] are forced to 00.
  - `trap` is tied 0 and TRAP is unreachable.

## Test plan
- Reset with RESET_PC=0, zero-wait memory returning 32'h0050_0093 (addi), `pcsel`=00 → `imem_req` first high in cycle 2, `commit` in cycle 3, next `imem_addr`=0x4.
- `imem_ack` delayed 3 cycles at pc=0x10 → FETCH held 3 extra cycles, `imem_addr` stable at 0x10, `instr_valid`=0 throughout.
- Load at pc=0x8 with `ramR`=1 → `instr_valid` high for 2 cycles, `commit` only in the second, next pc=0xC.
- Branch at pc=0x20, `immext`=-8:
  - `brtaken`=1 → next pc=0x18.
  - `brtaken`=0 → next pc=0x24.
- jalr with `aluresult`=0x103 at pc=0x40 → `pc4`=0x44.
  - Macro off: next pc=0x100.
  - Macro on: `trap`=1, pc stays 0x40.
- jal at pc=0xFFFF_FFFC with `immext`=8 → pc wraps to 0x4. Reset asserted during MEMWAIT → pc=RESET_PC, `commit` never pulses.
